// File: rtl/jk_pkg.sv
// Shared types and per-bit next-state function for the JK flip-flop bank.
package jk_pkg;

  typedef enum logic [1:0] {
    JK_MODE_JK = 2'b00,
    JK_MODE_T  = 2'b01,
    JK_MODE_D  = 2'b10,
    JK_MODE_SR = 2'b11
  } jk_mode_e;

  typedef struct packed {
    logic nxt;
    logic illegal;
  } jk_res_t;

  // Next state of one channel from the current state; illegal flags SR with both inputs high.
  function automatic jk_res_t jk_next(jk_mode_e mode, logic j, logic k, logic q);
    jk_res_t res;
    res.nxt     = q;
    res.illegal = 1'b0;
    case (mode)
      JK_MODE_JK: begin
        case ({j, k})
          2'b00:   res.nxt = q;
          2'b01:   res.nxt = 1'b0;
          2'b10:   res.nxt = 1'b1;
          default: res.nxt = ~q;
        endcase
      end
      JK_MODE_T:  res.nxt = j ? ~q : q;
      JK_MODE_D:  res.nxt = j;
      default: begin
        // SR with j=k=1 keeps the bit and reports the illegal combination.
        case ({j, k})
          2'b10:   res.nxt = 1'b1;
          2'b01:   res.nxt = 1'b0;
          2'b11: begin
            res.nxt     = q;
            res.illegal = 1'b1;
          end
          default: res.nxt = q;
        endcase
      end
    endcase
    return res;
  endfunction

endpackage

// File: rtl/jk_ff_cell.sv
// One channel of the bank: q/qb state flops with load > valid > hold priority.
module jk_ff_cell
  import jk_pkg::*;
#(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     load,
  input  logic     load_bit,
  input  logic     valid,
  input  jk_mode_e mode,
  input  logic     j,
  input  logic     k,
  output logic     q,
  output logic     qb,
  output logic     q_next,
  output logic     illegal
);

  logic    q_q, qb_q, q_d, illegal_d;
  jk_res_t res;

  // Next-state selection; illegal only reported when the op is actually applied.
  always_comb begin
    res       = jk_next(mode, j, k, q_q);
    q_d       = q_q;
    illegal_d = 1'b0;
    if (load) begin
      q_d = load_bit;
    end else if (valid) begin
      q_d       = res.nxt;
      illegal_d = res.illegal;
    end
  end

  // q and qb both come from the same next-state value so they never disagree.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q  <= RESET_BIT;
      qb_q <= ~RESET_BIT;
    end else begin
      q_q  <= q_d;
      qb_q <= ~q_d;
    end
  end

  assign q       = q_q;
  assign qb      = qb_q;
  assign q_next  = q_d;
  assign illegal = illegal_d;

endmodule

// File: rtl/jk_ff_bank.sv
// Bank of WIDTH JK/T/D/SR flip-flops with load, change flags, sticky SR error and change counter.
module jk_ff_bank
  import jk_pkg::*;
#(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0,
  parameter int                 CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  input  logic [WIDTH-1:0]  j,
  input  logic [WIDTH-1:0]  k,
  input  logic [1:0]        mode,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              clr_err,
  output logic [WIDTH-1:0]  q,
  output logic [WIDTH-1:0]  qb,
  output logic              out_valid,
  output logic [WIDTH-1:0]  changed,
  output logic              err,
  output logic [CNT_W-1:0]  chg_cnt
);

  logic [WIDTH-1:0] q_cur, q_next, illegal;
  jk_mode_e         mode_e;

  assign mode_e = jk_mode_e'(mode);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_ff_cell #(
      .RESET_BIT (RESET_VAL[i])
    ) u_cell (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .load_bit (load_val[i]),
      .valid    (valid),
      .mode     (mode_e),
      .j        (j[i]),
      .k        (k[i]),
      .q        (q_cur[i]),
      .qb       (qb[i]),
      .q_next   (q_next[i]),
      .illegal  (illegal[i])
    );
  end

  assign q = q_cur;

  logic             accepted;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] changed_q, changed_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] chg_cnt_q, chg_cnt_d;

  // Observability next-state: change mask, sticky error (set beats clear), saturating counter.
  always_comb begin
    accepted    = load | valid;
    out_valid_d = accepted;
    changed_d   = accepted ? (q_next ^ q_cur) : '0;
    err_d       = err_q;
    if (clr_err) err_d = 1'b0;
    if (valid && !load && (mode_e == JK_MODE_SR) && |illegal) err_d = 1'b1;
    chg_cnt_d   = chg_cnt_q;
    if (accepted && |changed_d && (chg_cnt_q != {CNT_W{1'b1}}))
      chg_cnt_d = chg_cnt_q + CNT_W'(1);
  end

  // Registered status outputs, cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      changed_q   <= '0;
      err_q       <= 1'b0;
      chg_cnt_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      changed_q   <= changed_d;
      err_q       <= err_d;
      chg_cnt_q   <= chg_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign changed   = changed_q;
  assign err       = err_q;
  assign chg_cnt   = chg_cnt_q;

endmodule

// File: tb/tb_jk_ff_bank.sv
// Directed-vector bench for jk_ff_bank (WIDTH=4, RESET_VAL=0101) plus a CNT_W=2 instance.
module tb_jk_ff_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid;
  logic [3:0] j, k, load_val;
  logic [1:0] mode;
  logic       load, clr_err;

  logic [3:0]  q, qb, changed;
  logic        out_valid, err;
  logic [15:0] chg_cnt;

  logic [3:0] s_q, s_qb, s_changed;
  logic       s_out_valid, s_err;
  logic [1:0] s_chg_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  jk_ff_bank #(.WIDTH(4), .RESET_VAL(4'b0101), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .valid(valid), .j(j), .k(k), .mode(mode),
    .load(load), .load_val(load_val), .clr_err(clr_err),
    .q(q), .qb(qb), .out_valid(out_valid), .changed(changed), .err(err), .chg_cnt(chg_cnt)
  );

  jk_ff_bank #(.WIDTH(4), .RESET_VAL(4'b0101), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .valid(valid), .j(j), .k(k), .mode(mode),
    .load(load), .load_val(load_val), .clr_err(clr_err),
    .q(s_q), .qb(s_qb), .out_valid(s_out_valid), .changed(s_changed), .err(s_err), .chg_cnt(s_chg_cnt)
  );

  task automatic idle_inputs();
    valid = 0; load = 0; clr_err = 0; j = '0; k = '0; load_val = '0; mode = 2'b00;
  endtask

  // Advance one active edge and return at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_state(string name, logic [3:0] eq, logic [3:0] ech, logic eov,
                           logic eerr, logic [15:0] ecnt);
    n_checks++;
    if (q !== eq || qb !== ~eq || changed !== ech || out_valid !== eov ||
        err !== eerr || chg_cnt !== ecnt) begin
      n_fail++;
      $display("FAIL %s: got q=%b qb=%b chg=%b ov=%b err=%b cnt=%0d, want q=%b qb=%b chg=%b ov=%b err=%b cnt=%0d",
               name, q, qb, changed, out_valid, err, chg_cnt, eq, ~eq, ech, eov, eerr, ecnt);
    end
  endtask

  task automatic test_jk();
    mode = 2'b00; valid = 1; j = 4'b1100; k = 4'b1010;
    step();
    chk_state("jk_op", 4'b1101, 4'b1000, 1'b1, 1'b0, 16'd1);
    idle_inputs();
    step();
    chk_state("jk_hold_idle", 4'b1101, 4'b0000, 1'b0, 1'b0, 16'd1);
  endtask

  task automatic test_toggle_d();
    load = 1; load_val = 4'b0000;
    step();
    chk_state("load_zero", 4'b0000, 4'b1101, 1'b1, 1'b0, 16'd2);
    idle_inputs();
    mode = 2'b01; valid = 1; j = 4'b1111; k = 4'b0000;
    step();
    chk_state("t_first", 4'b1111, 4'b1111, 1'b1, 1'b0, 16'd3);
    k = 4'b1010;
    step();
    chk_state("t_second", 4'b0000, 4'b1111, 1'b1, 1'b0, 16'd4);
    mode = 2'b10; j = 4'b0110; k = 4'b1111;
    step();
    chk_state("d_op", 4'b0110, 4'b0110, 1'b1, 1'b0, 16'd5);
    idle_inputs();
  endtask

  task automatic test_sr();
    load = 1; load_val = 4'b0000;
    step();
    chk_state("sr_preload", 4'b0000, 4'b0110, 1'b1, 1'b0, 16'd6);
    idle_inputs();
    mode = 2'b11; valid = 1; j = 4'b0011; k = 4'b0001;
    step();
    chk_state("sr_illegal", 4'b0010, 4'b0010, 1'b1, 1'b1, 16'd7);
    idle_inputs();
    clr_err = 1;
    step();
    chk_state("sr_clr", 4'b0010, 4'b0000, 1'b0, 1'b0, 16'd7);
    mode = 2'b11; valid = 1; j = 4'b0001; k = 4'b0001; clr_err = 1;
    step();
    chk_state("sr_set_beats_clr", 4'b0010, 4'b0000, 1'b1, 1'b1, 16'd7);
    idle_inputs();
    step();
    chk_state("sr_err_sticky", 4'b0010, 4'b0000, 1'b0, 1'b1, 16'd7);
  endtask

  task automatic test_load();
    load = 1; load_val = 4'b1010; valid = 1; mode = 2'b10; j = 4'b0101; k = 4'b1111;
    step();
    chk_state("load_wins", 4'b1010, 4'b1000, 1'b1, 1'b1, 16'd8);
    valid = 0;
    step();
    chk_state("load_same", 4'b1010, 4'b0000, 1'b1, 1'b1, 16'd8);
    idle_inputs();
  endtask

  task automatic test_reset();
    mode = 2'b01; valid = 1; j = 4'b1111;
    step();
    chk_state("pre_reset_t", 4'b0101, 4'b1111, 1'b1, 1'b1, 16'd9);
    #2 reset = 1;
    #1;
    chk_state("async_reset", 4'b0101, 4'b0000, 1'b0, 1'b0, 16'd0);
    n_checks++;
    if (s_q !== 4'b0101 || s_chg_cnt !== 2'd0 || s_err !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_reset: got q=%b cnt=%0d err=%b, want q=0101 cnt=0 err=0", s_q, s_chg_cnt, s_err);
    end
    @(negedge clk);
    step();
    chk_state("held_in_reset", 4'b0101, 4'b0000, 1'b0, 1'b0, 16'd0);
    idle_inputs();
    reset = 0;
    step();
  endtask

  task automatic test_saturate();
    logic [1:0] exp_s [5];
    exp_s[0] = 2'd1; exp_s[1] = 2'd2; exp_s[2] = 2'd3; exp_s[3] = 2'd3; exp_s[4] = 2'd3;
    mode = 2'b01; valid = 1; j = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (s_chg_cnt !== exp_s[i] || s_changed !== 4'b0001) begin
        n_fail++;
        $display("FAIL sat_cnt[%0d]: got cnt=%0d chg=%b, want cnt=%0d chg=0001", i, s_chg_cnt, s_changed, exp_s[i]);
      end
      n_checks++;
      if (chg_cnt !== 16'(i + 1)) begin
        n_fail++;
        $display("FAIL wide_cnt[%0d]: got %0d, want %0d", i, chg_cnt, i + 1);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    #1;
    chk_state("reset_state", 4'b0101, 4'b0000, 1'b0, 1'b0, 16'd0);
    @(negedge clk);
    reset = 0;
    test_jk();
    test_toggle_d();
    test_sr();
    test_load();
    test_reset();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
